// File: rtl/alu_pkg.sv
// Shared ALU constants used by the datapath logic units.
package alu_pkg;

  // Operand/result width of the integer datapath.
  localparam int ALU_WIDTH = 32;

  // All-zeros result, used as the reset value of registered results.
  localparam logic [ALU_WIDTH-1:0] ALU_ZERO = 32'h0000_0000;

endpackage : alu_pkg

// File: rtl/and_1bit.sv
// Single-bit AND cell; the leaf element of the bitwise AND unit.
module and_1bit (
  output logic out,
  input  logic a,
  input  logic b
);

  // One gate; X propagates with ordinary & semantics (0 & X = 0).
  assign out = a & b;

endmodule : and_1bit

// File: rtl/and_32bit.sv
// 32-bit bitwise AND unit for the ALU AND/ANDI path.
// Provides the combinational result and zero flag, plus a registered copy of
// both that lags by one clock and clears asynchronously on reset.
module and_32bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  output logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] rd_q,
  output logic             zero,
  output logic             zero_q
);

  // Heap-ordered OR tree: node n has children 2n+1 and 2n+2, the leaves
  // (indices WIDTH-1 .. 2*WIDTH-2) are the result bits, node 0 is the root.
  logic [2*WIDTH-2:0] or_node;
  logic [WIDTH-1:0]   rd_d;
  logic               zero_d;

  // Bit-sliced AND: one cell per result bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_and_cell
    and_1bit u_and (
      .out (rd[gi]),
      .a   (rs[gi]),
      .b   (rt[gi])
    );
  end

  // Feed result bits into the leaves of the reduction tree.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_leaf
    assign or_node[WIDTH-1+gi] = rd[gi];
  end

  // Internal tree nodes combine pairs of children.
  for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_or_node
    assign or_node[gi] = or_node[2*gi+1] | or_node[2*gi+2];
  end

  // Zero flag is the inverted root of the OR tree (a NOR reduction).
  assign zero = ~or_node[0];

  // Next-state values for the registered copy: capture every cycle.
  assign rd_d   = rd;
  assign zero_d = zero;

  // Registered result and flag; reset forces the "result is zero" state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= ALU_ZERO;
      zero_q <= 1'b1;
    end else begin
      rd_q   <= rd_d;
      zero_q <= zero_d;
    end
  end

endmodule : and_32bit

// File: tb/tb_and_32bit.sv
// Self-checking bench for and_32bit: directed vectors, reset behaviour and a
// randomized sweep against a plain-arithmetic reference model.
module tb_and_32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [31:0] rd;
  logic [31:0] rd_q;
  logic        zero;
  logic        zero_q;

  int n_vectors;
  int n_miscompares;

  and_32bit dut (
    .rd     (rd),
    .rs     (rs),
    .rt     (rt),
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_q   (rd_q),
    .zero   (zero),
    .zero_q (zero_q)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report any difference.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: pure arithmetic from the operand values.
  function automatic logic [31:0] ref_and(input logic [31:0] a, input logic [31:0] b);
    return a & b;
  endfunction

  function automatic logic [31:0] ref_zero(input logic [31:0] a, input logic [31:0] b);
    return {31'b0, ((a & b) == 32'h0)};
  endfunction

  // Apply one combinational vector, hold 20 units, check rd and zero.
  task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_rd, input logic exp_zero);
    rs = a;
    rt = b;
    #20;
    check({tag, ".rd"}, rd, exp_rd);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_zero});
  endtask

  logic [31:0] prev_rd;
  logic [31:0] prev_zero;
  logic [31:0] a_r;
  logic [31:0] b_r;
  bit          has_prev;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n = 1'b1;
    rs    = 32'h0;
    rt    = 32'h0;
    $monitor("%0t rs=%b rt=%b rd=%b", $time, rs, rt, rd);

    // Reset asserted before any clock edge: registered outputs clear at once.
    #2 rst_n = 1'b0;
    #1;
    check("reset.rd_q", rd_q, 32'h0);
    check("reset.zero_q", {31'b0, zero_q}, 32'h1);

    // Directed combinational vectors, applied while still in reset.
    comb_vec("t1", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    comb_vec("t2", 32'h0F80_0000, 32'hFFFF_FFFF, 32'h0F80_0000, 1'b0);
    comb_vec("t3a", 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1);
    comb_vec("t3b", 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0);
    // Clock edges have passed during reset; registers must still be cleared.
    check("hold_in_reset.rd_q", rd_q, 32'h0);
    check("hold_in_reset.zero_q", {31'b0, zero_q}, 32'h1);

    // Release reset and capture one known vector.
    @(negedge clk);
    rst_n = 1'b1;
    rs    = 32'h1234_5678;
    rt    = 32'hFFFF_0000;
    #1;
    check("t4.pre_edge.rd_q", rd_q, 32'h0);
    @(posedge clk);
    #1;
    check("t4.rd_q", rd_q, 32'h1234_0000);
    check("t4.zero_q", {31'b0, zero_q}, 32'h0);

    // Inputs change between edges: rd follows, rd_q holds until next edge.
    @(negedge clk);
    rs = 32'hF0F0_F0F0;
    rt = 32'h0FF0_0FF0;
    #1;
    check("t5.rd_follows", rd, 32'h00F0_00F0);
    check("t5.rd_q_holds", rd_q, 32'h1234_0000);
    @(posedge clk);
    #1;
    check("t5.rd_q_capture", rd_q, 32'h00F0_00F0);

    // Mid-cycle reset clears the register with no clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5.async_rst.rd_q", rd_q, 32'h0);
    check("t5.async_rst.zero_q", {31'b0, zero_q}, 32'h1);
    check("t5.rd_in_reset", rd, 32'h00F0_00F0);

    // Random sweep: every vector checks comb outputs and previous-cycle registers.
    @(negedge clk);
    rst_n    = 1'b1;
    has_prev = 1'b0;
    prev_rd   = 32'h0;
    prev_zero = 32'h0;
    for (int i = 0; i < 1000; i++) begin
      if (i != 0) @(negedge clk);
      if (has_prev) begin
        check("rand.rd_q", rd_q, prev_rd);
        check("rand.zero_q", {31'b0, zero_q}, prev_zero);
      end
      a_r = $urandom;
      b_r = $urandom;
      // Some vectors are forced to produce a zero result.
      if ((i % 8) == 3) b_r = ~a_r & $urandom;
      rs = a_r;
      rt = b_r;
      #1;
      check("rand.rd", rd, ref_and(a_r, b_r));
      check("rand.zero", {31'b0, zero}, ref_zero(a_r, b_r));
      prev_rd   = ref_and(a_r, b_r);
      prev_zero = ref_zero(a_r, b_r);
      has_prev  = 1'b1;
    end
    @(negedge clk);
    check("rand.last.rd_q", rd_q, prev_rd);
    check("rand.last.zero_q", {31'b0, zero_q}, prev_zero);

    $monitoroff;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_and_32bit
